// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: datapath widths, FSM encodings
// and the per-cycle step limit of the shifter.
package shift_sequencer_pkg;

  localparam int WIDTH    = 4;
  localparam int AMT_W    = 4;
  localparam int MAX_STEP = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Largest step the shifter can take this cycle without overshooting rem.
  function automatic logic [1:0] step_for(input logic [AMT_W-1:0] rem);
    return (rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and result handshake bundle between a consumer (master) and the
// shift sequencer (slave).
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_sr;
  logic [AMT_W-1:0] cmd_amt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport master (
    output cmd_valid, cmd_data, cmd_sr, cmd_amt, res_ready,
    input  cmd_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_sr, cmd_amt, res_ready,
    output cmd_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Combinational 4-bit zero-fill shifter, 0..3 positions per pass; shamt=0
// passes the input through unchanged.
module shifter
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr,
  input  logic [1:0]       shamt,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = sr ? (data_in >> shamt) : (data_in << shamt);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven iterative shifter: accepts a word and a total distance, walks
// it through the shifter at most MAX_STEP positions per cycle, returns the result.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  shift_sequencer_if.slave bus
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [AMT_W-1:0] rem_reg;
  logic             dir_reg;
  logic             cmd_ready_reg;
  logic             res_valid_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] res_data_reg;

  logic [1:0]       step;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] shift_out;

  // rem is nonzero throughout SHIFT, so step is never zero when acc loads from it.
  assign step     = step_for(rem_reg);
  assign rem_next = rem_reg - AMT_W'(step);

  shifter u_shifter (
    .data_in  (acc_reg),
    .sr       (dir_reg),
    .shamt    (step),
    .data_out (shift_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      rem_reg       <= '0;
      dir_reg       <= 1'b0;
      cmd_ready_reg <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_reg) begin
            acc_reg       <= bus.cmd_data;
            dir_reg       <= bus.cmd_sr;
            rem_reg       <= bus.cmd_amt;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= (bus.cmd_amt == '0) ? S_DONE : S_SHIFT;
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end
        S_SHIFT: begin
          acc_reg <= shift_out;
          rem_reg <= rem_next;
          if (rem_next == '0) begin
            state_reg     <= S_DONE;
            res_valid_reg <= 1'b1;
            res_data_reg  <= shift_out;
          end
        end
        S_DONE: begin
          // A zero-distance command arrives here straight from IDLE and
          // presents its word one cycle later, keeping latency at least 1.
          if (!res_valid_reg) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= acc_reg;
          end else if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed scoreboard bench for shift_sequencer: the driver queues expected
// words and latencies, a negedge monitor checks each delivered result.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] data;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on first sight of res_valid, data on the handshake.
  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (q.size() == 0) begin
        if (!seen) begin
          checks++;
          $display("FAIL unexpected_result: got res_data=%0d, expected no result", bus.res_data);
          seen = 1'b1;
        end
      end else begin
        if (!seen) begin
          check("latency", cyc - q[0].acc_cyc, q[0].lat);
          seen = 1'b1;
        end
        if (bus.res_ready) begin
          check("res_data", int'(bus.res_data), int'(q[0].data));
          $display("result data=%b lat=%0d", bus.res_data, q[0].lat);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic sr, input logic [3:0] amt,
                      input logic [3:0] exp_d, input int lat, input bit track);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_sr    = sr;
    bus.cmd_amt   = amt;
    n = 0;
    while (!bus.cmd_ready && n < 60) begin
      tick();
      n++;
    end
    if (n == 60) begin
      checks++;
      $display("FAIL accept_timeout: got cmd_ready=0, expected 1 within 60 cycles");
    end else begin
      check("accept_in_idle_busy", int'(bus.busy), 0);
      if (track) q.push_back('{data: exp_d, lat: lat, acc_cyc: cyc + 1});
      $display("cmd %s data=%b amt=%0d expect=%b", sr ? "R" : "L", d, amt, exp_d);
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.res_valid) && n < 60) begin
      tick();
      n++;
    end
    if (n == 60) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_sr    = 1'b0;
    bus.cmd_amt   = '0;
    bus.res_ready = 1'b1;

    // Reset state and cmd_ready rising one edge after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_data", int'(bus.res_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cmd_ready", int'(bus.cmd_ready), 0);
    rst = 1'b0;
    #1;
    check("release_cmd_ready_no_edge", int'(bus.cmd_ready), 0);
    tick();
    check("release_cmd_ready_after_edge", int'(bus.cmd_ready), 1);

    // Basic shifts
    send(4'b1011, 1'b0, 4'd1, 4'b0110, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();
    send(4'b1000, 1'b1, 4'd7, 4'b0000, 3, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();
    send(4'b1100, 1'b1, 4'd2, 4'b0011, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();
    send(4'b0101, 1'b0, 4'd0, 4'b0101, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();
    send(4'b0001, 1'b0, 4'd3, 4'b1000, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();

    // Back-pressure in DONE with an ignored command pulse
    bus.res_ready = 1'b0;
    send(4'b0011, 1'b0, 4'd1, 4'b0110, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", int'(bus.res_valid), 1);
      check("hold_res_data", int'(bus.res_data), 6);
      check("hold_cmd_ready", int'(bus.cmd_ready), 0);
      if (i == 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b1111;
        bus.cmd_sr    = 1'b1;
        bus.cmd_amt   = 4'd0;
      end
      if (i == 3) bus.cmd_valid = 1'b0;
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("release_res_valid", int'(bus.res_valid), 0);
    check("release_cmd_ready", int'(bus.cmd_ready), 1);
    check("release_busy", int'(bus.busy), 0);
    check("idle_res_data_kept", int'(bus.res_data), 6);
    repeat (3) tick();
    check("pulse_not_captured", int'(bus.res_valid), 0);

    // Asynchronous reset in the middle of a long shift
    send(4'b1111, 1'b1, 4'd15, 4'b0000, 5, 1'b0);
    bus.cmd_valid = 1'b0;
    tick();
    check("mid_shift_busy", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_res_valid", int'(bus.res_valid), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_cmd_ready", int'(bus.cmd_ready), 0);
    check("async_rst_res_data", int'(bus.res_data), 0);
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    seen = 1'b0;
    tick();
    check("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
    send(4'b0001, 1'b0, 4'd2, 4'b0100, 1, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();

    // Back-to-back commands with cmd_valid held and res_ready tied high
    send(4'b1001, 1'b0, 4'd0, 4'b1001, 1, 1'b1);
    send(4'b1110, 1'b1, 4'd3, 4'b0001, 1, 1'b1);
    send(4'b0011, 1'b0, 4'd4, 4'b0000, 2, 1'b1);
    send(4'b1111, 1'b1, 4'd15, 4'b0000, 5, 1'b1);
    bus.cmd_valid = 1'b0;
    drain();
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
